// File: rtl/stq_fwd_pkg.sv
// stq_fwd_pkg: shared sizing defaults for the store queue
package stq_fwd_pkg;
  localparam int STQ_DEPTH_DEF = 16;
  localparam int STQ_IDX_DEF = 4;
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
endpackage

// File: rtl/stq_fwd_search.sv
// stq_fwd_search: youngest-first scan for the nearest older store to a load
module stq_fwd_search
  import stq_fwd_pkg::*;
#(
  parameter int STQ_DEPTH = STQ_DEPTH_DEF,
  parameter int STQ_IDX = STQ_IDX_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [STQ_IDX:0]    head,
  input  logic [STQ_IDX:0]    ld_age,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [ADDR_W-1:0]   addr [STQ_DEPTH],
  input  logic [STQ_DEPTH-1:0] rdy,
  output logic                hit,
  output logic                blk,
  output logic [STQ_IDX-1:0]  sel
);
  localparam int T = STQ_IDX + 1;
  logic [T-1:0] span;
  logic [STQ_IDX-1:0] idx;
  assign span = ld_age - head;
  always_comb begin
    hit = 1'b0;
    blk = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = 0; k < STQ_DEPTH; k++) begin
      idx = ld_age[STQ_IDX-1:0] - STQ_IDX'(k + 1);
      if (!hit && !blk && T'(k) < span) begin
        if (!rdy[idx]) blk = 1'b1;
        else if (addr[idx] == ld_addr) begin
          hit = 1'b1;
          sel = idx;
        end
      end
    end
  end
endmodule

// File: rtl/stq_fwd.sv
// stq_fwd: store queue with age tags, load forwarding, in-order drain and flush
module stq_fwd
  import stq_fwd_pkg::*;
#(
  parameter int STQ_DEPTH = STQ_DEPTH_DEF,
  parameter int STQ_IDX = STQ_IDX_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         disp_valid,
  output logic               disp_ready,
  output logic [STQ_IDX:0]   disp_age0,
  output logic [STQ_IDX:0]   disp_age1,
  input  logic [1:0]         iss_valid,
  input  logic [STQ_IDX:0]   iss_age0,
  input  logic [STQ_IDX:0]   iss_age1,
  input  logic [ADDR_W-1:0]  iss_addr0,
  input  logic [ADDR_W-1:0]  iss_addr1,
  input  logic [DATA_W-1:0]  iss_data0,
  input  logic [DATA_W-1:0]  iss_data1,
  input  logic               ld_valid,
  input  logic [STQ_IDX:0]   ld_age,
  input  logic [ADDR_W-1:0]  ld_addr,
  output logic               fwd_valid,
  output logic               fwd_hit,
  output logic               fwd_wait,
  output logic [DATA_W-1:0]  fwd_data,
  input  logic [1:0]         ret_cnt,
  input  logic               flush,
  output logic               dc_wr_valid,
  input  logic               dc_wr_ready,
  output logic [ADDR_W-1:0]  dc_wr_addr,
  output logic [DATA_W-1:0]  dc_wr_data,
  output logic               stq_empty,
  output logic [STQ_IDX:0]   stq_count
);
  localparam int T = STQ_IDX + 1;
  logic [T-1:0] head, cmt, tail, count, cmt_n, n_alloc;
  logic [T-1:0] iss_age [2];
  logic [ADDR_W-1:0] iss_addr [2];
  logic [DATA_W-1:0] iss_data [2];
  logic [ADDR_W-1:0] addr_q [STQ_DEPTH];
  logic [DATA_W-1:0] data_q [STQ_DEPTH];
  logic [STQ_DEPTH-1:0] rdy;
  logic alloc, drain, hit, blk;
  logic [STQ_IDX-1:0] sel;
  assign iss_age[0] = iss_age0;
  assign iss_age[1] = iss_age1;
  assign iss_addr[0] = iss_addr0;
  assign iss_addr[1] = iss_addr1;
  assign iss_data[0] = iss_data0;
  assign iss_data[1] = iss_data1;
  assign count = tail - head;
  assign stq_count = count;
  assign stq_empty = count == '0;
  assign disp_ready = count <= T'(STQ_DEPTH - 2);
  assign disp_age0 = tail;
  assign disp_age1 = tail + T'(disp_valid[0]);
  assign alloc = disp_ready && !flush;
  assign n_alloc = alloc ? T'(disp_valid[0]) + T'(disp_valid[1]) : '0;
  assign cmt_n = cmt + T'(ret_cnt);
  assign dc_wr_valid = head != cmt;
  assign drain = dc_wr_valid && dc_wr_ready;
  assign dc_wr_addr = addr_q[head[STQ_IDX-1:0]];
  assign dc_wr_data = data_q[head[STQ_IDX-1:0]];
  function automatic logic live(input logic [T-1:0] tag);
    return T'(tag - head) < count;
  endfunction
  stq_fwd_search #(.STQ_DEPTH(STQ_DEPTH), .STQ_IDX(STQ_IDX), .ADDR_W(ADDR_W)) u_search (
    .head(head), .ld_age(ld_age), .ld_addr(ld_addr), .addr(addr_q), .rdy(rdy),
    .hit(hit), .blk(blk), .sel(sel)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      cmt <= '0;
      tail <= '0;
      rdy <= '0;
      fwd_valid <= 1'b0;
      fwd_hit <= 1'b0;
      fwd_wait <= 1'b0;
      fwd_data <= '0;
    end else begin
      assert (T'(ret_cnt) <= T'(tail - cmt));
      head <= head + T'(drain);
      cmt <= cmt_n;
      tail <= flush ? cmt_n : tail + n_alloc;
      for (int w = 0; w < 2; w++) begin
        if (iss_valid[w]) assert (live(iss_age[w]));
        if (iss_valid[w] && live(iss_age[w])) rdy[iss_age[w][STQ_IDX-1:0]] <= 1'b1;
      end
      if (alloc && disp_valid[0]) rdy[disp_age0[STQ_IDX-1:0]] <= 1'b0;
      if (alloc && disp_valid[1]) rdy[disp_age1[STQ_IDX-1:0]] <= 1'b0;
      fwd_valid <= ld_valid;
      fwd_hit <= ld_valid && hit;
      fwd_wait <= ld_valid && blk;
      fwd_data <= (ld_valid && hit) ? data_q[sel] : '0;
    end
  end
  always_ff @(posedge clock) begin
    for (int w = 0; w < 2; w++)
      if (!reset && iss_valid[w] && live(iss_age[w])) begin
        addr_q[iss_age[w][STQ_IDX-1:0]] <= iss_addr[w];
        data_q[iss_age[w][STQ_IDX-1:0]] <= iss_data[w];
      end
  end
endmodule

// File: tb/tb_stq_fwd.sv
// tb_stq_fwd: directed stimulus against a sequence-number store queue model
module tb_stq_fwd;
  localparam int D = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] disp_valid, iss_valid, ret_cnt;
  logic disp_ready, ld_valid, fwd_valid, fwd_hit, fwd_wait, flush;
  logic dc_wr_valid, dc_wr_ready, stq_empty;
  logic [4:0] disp_age0, disp_age1, iss_age0, iss_age1, ld_age, stq_count;
  logic [63:0] iss_addr0, iss_addr1, iss_data0, iss_data1, ld_addr, fwd_data, dc_wr_addr, dc_wr_data;
  int errs = 0;
  int checks = 0;
  bit chk_on = 0;
  int m_head, m_cmt, m_tail;
  bit m_rdy [1024];
  logic [63:0] m_addr [1024];
  logic [63:0] m_data [1024];
  logic e_fv, e_hit, e_wait;
  logic [63:0] e_data;
  always #5 clock = ~clock;
  stq_fwd dut (
    .clock(clock), .reset(reset), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_age0(disp_age0), .disp_age1(disp_age1), .iss_valid(iss_valid),
    .iss_age0(iss_age0), .iss_age1(iss_age1), .iss_addr0(iss_addr0), .iss_addr1(iss_addr1),
    .iss_data0(iss_data0), .iss_data1(iss_data1), .ld_valid(ld_valid), .ld_age(ld_age),
    .ld_addr(ld_addr), .fwd_valid(fwd_valid), .fwd_hit(fwd_hit), .fwd_wait(fwd_wait),
    .fwd_data(fwd_data), .ret_cnt(ret_cnt), .flush(flush), .dc_wr_valid(dc_wr_valid),
    .dc_wr_ready(dc_wr_ready), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .stq_empty(stq_empty), .stq_count(stq_count)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int seq_of(input logic [4:0] t);
    return m_head + ((int'(t) - m_head) & 31);
  endfunction
  task automatic m_issue(input logic [4:0] t, input logic [63:0] a, input logic [63:0] d);
    int s;
    s = seq_of(t);
    if (s < m_tail) begin
      m_rdy[s] = 1;
      m_addr[s] = a;
      m_data[s] = d;
    end
  endtask
  always @(posedge clock) begin
    if (reset) begin
      m_head = 0;
      m_cmt = 0;
      m_tail = 0;
      e_fv = 0;
      e_hit = 0;
      e_wait = 0;
      e_data = 0;
    end else begin
      bit done, dr;
      e_fv = ld_valid;
      e_hit = 0;
      e_wait = 0;
      e_data = 0;
      done = 0;
      if (ld_valid)
        for (int q = seq_of(ld_age) - 1; q >= m_head; q--)
          if (!done) begin
            if (!m_rdy[q]) begin e_wait = 1; done = 1; end
            else if (m_addr[q] == ld_addr) begin e_hit = 1; e_data = m_data[q]; done = 1; end
          end
      if (iss_valid[0]) m_issue(iss_age0, iss_addr0, iss_data0);
      if (iss_valid[1]) m_issue(iss_age1, iss_addr1, iss_data1);
      if (!flush && m_tail - m_head <= D - 2) begin
        if (disp_valid[0]) begin m_rdy[m_tail] = 0; m_tail = m_tail + 1; end
        if (disp_valid[1]) begin m_rdy[m_tail] = 0; m_tail = m_tail + 1; end
      end
      dr = (m_head != m_cmt) && dc_wr_ready;
      m_cmt = m_cmt + int'(ret_cnt);
      if (dr) m_head = m_head + 1;
      if (flush) m_tail = m_cmt;
    end
  end
  always @(negedge clock) if (chk_on) begin
    chk("disp_ready", disp_ready, 64'(m_tail - m_head <= D - 2));
    chk("disp_age0", disp_age0, 64'(m_tail & 31));
    chk("disp_age1", disp_age1, 64'((m_tail + int'(disp_valid[0])) & 31));
    chk("stq_count", stq_count, 64'(m_tail - m_head));
    chk("stq_empty", stq_empty, 64'(m_tail == m_head));
    chk("dc_wr_valid", dc_wr_valid, 64'(m_head != m_cmt));
    if (m_head != m_cmt) begin
      chk("dc_wr_addr", dc_wr_addr, m_addr[m_head]);
      chk("dc_wr_data", dc_wr_data, m_data[m_head]);
    end
    chk("fwd_valid", fwd_valid, e_fv);
    chk("fwd_hit", fwd_hit, e_hit);
    chk("fwd_wait", fwd_wait, e_wait);
    if (e_hit) chk("fwd_data", fwd_data, e_data);
  end
  task automatic step();
    @(posedge clock);
    #2;
  endtask
  task automatic idle();
    disp_valid = 0; iss_valid = 0; ret_cnt = 0; flush = 0; ld_valid = 0; dc_wr_ready = 0;
    iss_age0 = 0; iss_age1 = 0; iss_addr0 = 0; iss_addr1 = 0; iss_data0 = 0; iss_data1 = 0;
    ld_age = 0; ld_addr = 0;
  endtask
  task automatic iss(input int w, input logic [4:0] t, input logic [63:0] a, input logic [63:0] d);
    iss_valid[w] = 1'b1;
    if (w == 0) begin iss_age0 = t; iss_addr0 = a; iss_data0 = d; end
    else begin iss_age1 = t; iss_addr1 = a; iss_data1 = d; end
  endtask
  task automatic probe(input logic [4:0] t, input logic [63:0] a);
    ld_valid = 1; ld_age = t; ld_addr = a;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    idle();
    step(); step();
    reset = 0; chk_on = 1; #1;
    chk("rst count", stq_count, 0); chk("rst empty", stq_empty, 1);
    chk("rst disp_ready", disp_ready, 1); chk("rst fwd_valid", fwd_valid, 0);
    chk("rst fwd_data", fwd_data, 0); chk("rst dc_valid", dc_wr_valid, 0);
    disp_valid = 2'b11; #1;
    chk("age0 first", disp_age0, 0); chk("age1 first", disp_age1, 1);
    step(); idle(); #1;
    chk("count after alloc", stq_count, 2); chk("dc idle", dc_wr_valid, 0);
    iss(0, 0, 'h100, 'hAA); step(); idle();
    probe(2, 'h100); step(); idle(); #1;
    chk("probe wait valid", fwd_valid, 1); chk("probe wait", fwd_wait, 1); chk("probe wait hit", fwd_hit, 0);
    iss(1, 1, 'h200, 'hBB); step(); idle();
    probe(2, 'h100); step(); idle(); #1;
    chk("probe hit", fwd_hit, 1); chk("probe hit data", fwd_data, 'hAA);
    disp_valid = 2'b11; step(); idle();
    iss(0, 2, 'h100, 'h11); iss(1, 3, 'h100, 'h22); step(); idle();
    probe(4, 'h100); step(); idle(); #1;
    chk("youngest data", fwd_data, 'h22);
    probe(3, 'h100); step(); idle(); #1;
    chk("older data", fwd_data, 'h11);
    probe(4, 'h300); step(); idle(); #1;
    chk("miss hit", fwd_hit, 0); chk("miss wait", fwd_wait, 0);
    probe(0, 'h100); step(); idle(); #1;
    chk("at head hit", fwd_hit, 0); chk("at head wait", fwd_wait, 0);
    repeat (6) begin disp_valid = 2'b11; step(); end
    idle(); #1;
    chk("full count", stq_count, 16); chk("full ready", disp_ready, 0);
    disp_valid = 2'b11; step(); idle(); #1;
    chk("full no alloc", stq_count, 16);
    ret_cnt = 2; step(); idle();
    repeat (3) begin
      step(); #1;
      chk("hold valid", dc_wr_valid, 1); chk("hold addr", dc_wr_addr, 'h100); chk("hold data", dc_wr_data, 'hAA);
    end
    dc_wr_ready = 1; step(); #1;
    chk("drain1 addr", dc_wr_addr, 'h200); chk("drain1 count", stq_count, 15);
    step(); dc_wr_ready = 0; #1;
    chk("drain2 valid", dc_wr_valid, 0); chk("drain2 count", stq_count, 14);
    disp_valid = 2'b11; #1;
    chk("wrap age0", disp_age0, 'h10); chk("wrap age1", disp_age1, 'h11);
    step(); idle(); #1;
    chk("wrap count", stq_count, 16);
    reset = 1; step(); reset = 0;
    disp_valid = 2'b11; step(); step(); idle();
    iss(0, 0, 'h500, 'hD0); iss(1, 1, 'h508, 'hD1); step();
    idle(); iss(0, 2, 'h510, 'hD2); iss(1, 3, 'h518, 'hD3); step(); idle();
    ret_cnt = 1; step(); idle(); #1;
    chk("pre flush count", stq_count, 4);
    flush = 1; ret_cnt = 1; disp_valid = 2'b11; probe(4, 'h518); step(); idle(); #1;
    chk("flush count", stq_count, 2); chk("flush tail", disp_age0, 2);
    chk("flush probe valid", fwd_valid, 1); chk("flush probe data", fwd_data, 'hD3);
    disp_valid = 2'b11; step(); idle();
    probe(4, 'h518); step(); idle(); #1;
    chk("squashed wait", fwd_wait, 1); chk("squashed hit", fwd_hit, 0);
    dc_wr_ready = 1; #1;
    chk("mid drain valid", dc_wr_valid, 1);
    reset = 1; step(); reset = 0; idle(); #1;
    chk("reset dc_valid", dc_wr_valid, 0); chk("reset count", stq_count, 0);
    chk("reset empty", stq_empty, 1); chk("reset ready", disp_ready, 1); chk("reset fwd", fwd_valid, 0);
    step(); step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
